// File: rtl/uart_io_ctrl_pkg.sv
// uart_io_ctrl_pkg: shared TX state encoding and default RX FIFO depth
package uart_io_ctrl_pkg;
  localparam int IO_RX_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {
    IO_T_IDLE = 2'd0,
    IO_T_FIRE = 2'd1,
    IO_T_BUSY = 2'd2,
    IO_T_DONE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_io_ctrl_rx_fifo.sv
// io_rx_fifo: byte FIFO (push/pop, din/dout, empty/full); pop on empty is ignored, push on full is accepted only alongside a pop
module io_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;
  always_comb begin
    empty    = cnt_q == '0;
    full     = cnt_q == (PTR_W+1)'(FIFO_DEPTH);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    dout     = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: programmed-I/O glue; uart_rx side (rx_*) feeds INPR/FGI via FIFO, OUTR/FGO drive uart_tx (tx_*), CPU side (ac_in, inp_rd, out_wr, ion/iof/int_ack, err_clr) plus flags and irq
module uart_io_ctrl
  import uart_io_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = IO_RX_FIFO_DEPTH,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  input  logic       rx_error,
  output logic [7:0] tx_byte,
  output logic       tx_fgo,
  input  logic       tx_rdy,
  input  logic [7:0] ac_in,
  input  logic       inp_rd,
  input  logic       out_wr,
  input  logic       ion,
  input  logic       iof,
  input  logic       int_ack,
  input  logic       err_clr,
  output logic [7:0] inpr,
  output logic       fgi,
  output logic       fgo,
  output logic       ien,
  output logic       irq,
  output logic       ovf,
  output logic       err
);
  tx_state_e  state_q, state_d;
  logic [7:0] outr_q, outr_d;
  logic       rx_s_q, rx_p_q, fgo_q, fgo_d, ien_q, ien_d, ovf_q, ovf_d, err_q, err_d;
  logic       rise, push, empty, full;
  io_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(inp_rd),
    .din(rx_byte), .dout(inpr), .empty(empty), .full(full)
  );
  always_comb begin
    rise    = rx_s_q & ~rx_p_q;
    push    = rise & ~rx_error;
    fgi     = ~empty;
    ovf_d   = (push & full & ~inp_rd) | (ovf_q & ~err_clr);
    err_d   = (rise & rx_error) | (err_q & ~err_clr);
    ien_d   = (int_ack | iof) ? 1'b0 : ion ? 1'b1 : ien_q;
    state_d = state_q;
    fgo_d   = fgo_q;
    outr_d  = outr_q;
    case (state_q)
      IO_T_IDLE: if (out_wr & fgo_q) begin
        outr_d  = ac_in;
        fgo_d   = 1'b0;
        state_d = IO_T_FIRE;
      end
      IO_T_FIRE: state_d = IO_T_BUSY;
      IO_T_BUSY: state_d = tx_rdy ? IO_T_BUSY : IO_T_DONE;
      IO_T_DONE: if (tx_rdy) begin
        fgo_d   = 1'b1;
        state_d = IO_T_IDLE;
      end
      default:   state_d = IO_T_IDLE;
    endcase
    tx_fgo  = state_q != IO_T_FIRE;
    tx_byte = outr_q;
    fgo     = fgo_q;
    ien     = ien_q;
    ovf     = ovf_q;
    err     = err_q;
    irq     = ien_q & (fgi | fgo_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s_q  <= 1'b0;
      rx_p_q  <= 1'b0;
      state_q <= IO_T_IDLE;
      outr_q  <= '0;
      fgo_q   <= 1'b1;
      ien_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_s_q  <= rx_rdy;
      rx_p_q  <= rx_s_q;
      state_q <= state_d;
      outr_q  <= outr_d;
      fgo_q   <= fgo_d;
      ien_q   <= ien_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb_uart_io_ctrl: scoreboard bench with a queue-based RX model, uart_tx responder and randomized traffic
module tb_uart_io_ctrl;
  localparam int DEPTH = 4;
  logic       clk = 0, reset_n = 0;
  logic [7:0] rx_byte = 0, ac_in = 0;
  logic       rx_rdy = 0, rx_error = 0, tx_rdy = 1;
  logic       inp_rd = 0, out_wr = 0, ion = 0, iof = 0, int_ack = 0, err_clr = 0;
  logic [7:0] tx_byte, inpr;
  logic       tx_fgo, fgi, fgo, ien, irq, ovf, err;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  logic [7:0] txq[$];
  logic [7:0] txb_m;
  bit fgo_m, ien_m, ovf_m, err_m;
  int ph, cd;
  uart_io_ctrl dut (
    .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_rdy(rx_rdy), .rx_error(rx_error),
    .tx_byte(tx_byte), .tx_fgo(tx_fgo), .tx_rdy(tx_rdy), .ac_in(ac_in), .inp_rd(inp_rd),
    .out_wr(out_wr), .ion(ion), .iof(iof), .int_ack(int_ack), .err_clr(err_clr),
    .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq), .ovf(ovf), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic mreset();
    q.delete();
    txq.delete();
    fgo_m = 1; ien_m = 0; ovf_m = 0; err_m = 0; txb_m = 0; ph = 0; cd = 0;
  endtask
  // advance one clock and apply the spec's effect of this cycle's inputs to the model
  task automatic step();
    @(posedge clk);
    if (!reset_n) mreset();
    else begin
      bit pop, arr, so, se;
      pop = inp_rd && q.size() > 0;
      arr = 0;
      if (cd > 0) begin cd--; arr = (cd == 0); end
      so = arr && !rx_error && q.size() == DEPTH && !pop;
      se = arr && rx_error;
      if (pop) void'(q.pop_front());
      if (arr && !rx_error && !so) q.push_back(rx_byte);
      ovf_m = so | (ovf_m & !err_clr);
      err_m = se | (err_m & !err_clr);
      if (int_ack || iof) ien_m = 0; else if (ion) ien_m = 1;
      case (ph)
        0: if (out_wr) begin txb_m = ac_in; fgo_m = 0; ph = 1; txq.push_back(ac_in); end
        1: ph = 2;
        2: if (!tx_rdy) ph = 3;
        default: if (tx_rdy) begin ph = 0; fgo_m = 1; end
      endcase
    end
    #1;
  endtask
  task automatic frame(logic [7:0] b, bit e, bit pop);
    rx_byte = b; rx_error = e; rx_rdy = 1; cd = 2;
    step();
    inp_rd = pop;
    step();
    inp_rd = 0;
    step();
    rx_rdy = 0;
    step();
  endtask
  task automatic pop1();
    inp_rd = 1; step(); inp_rd = 0;
  endtask
  task automatic wait_tx_idle();
    int n = 0;
    while (!fgo_m && n < 60) begin step(); n++; end
    if (!fgo_m) begin tests++; fails++; $display("FAIL tx_timeout: fgo still 0 after %0d cycles", n); end
  endtask
  always @(negedge clk) begin
    chk("fgi", fgi, q.size() > 0);
    if (q.size() > 0) chk("inpr", inpr, q[0]);
    chk("ovf", ovf, ovf_m);
    chk("err", err, err_m);
    chk("ien", ien, ien_m);
    chk("irq", irq, ien_m & (q.size() > 0 || fgo_m));
    chk("fgo", fgo, fgo_m);
    chk("tx_fgo", tx_fgo, ph != 1);
    chk("tx_byte", tx_byte, txb_m);
  end
  // uart_tx responder: takes the byte on the tx_fgo low pulse, then busy for a 10-bit frame
  initial forever begin
    @(negedge clk);
    if (reset_n && !tx_fgo) begin
      chk("tx_sent", tx_byte, txq.size() > 0 ? txq[0] : 8'hxx);
      if (txq.size() > 0) void'(txq.pop_front());
      @(posedge clk); #1 tx_rdy = 0;
      for (int i = 0; i < 10 && reset_n; i++) @(posedge clk);
      #1 tx_rdy = 1;
    end
  end
  initial begin
    mreset();
    repeat (3) step();
    reset_n = 1;
    step();
    frame(8'h41, 0, 0);
    step();
    pop1();
    step();
    for (int i = 0; i < 5; i++) frame(8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) pop1();
    err_clr = 1; step(); err_clr = 0;
    for (int i = 0; i < 4; i++) frame(8'h1c + 8'(i), 0, 0);
    frame(8'h20, 0, 1);
    for (int i = 0; i < 5; i++) pop1();
    ac_in = 8'h5A; out_wr = 1; step(); out_wr = 0;
    repeat (3) step();
    ac_in = 8'hA5; out_wr = 1; step(); out_wr = 0;
    wait_tx_idle();
    step();
    ion = 1; step(); ion = 0;
    frame(8'h77, 0, 0);
    int_ack = 1; ion = 1; step(); int_ack = 0;
    step();
    iof = 1; step(); iof = 0; ion = 0;
    step();
    frame(8'hEE, 1, 0);
    pop1();
    err_clr = 1; step(); err_clr = 0;
    frame(8'h33, 0, 0);
    ac_in = 8'hC3; out_wr = 1; step(); out_wr = 0;
    repeat (4) step();
    #1 reset_n = 0; mreset();
    step(); step();
    #1 reset_n = 1;
    step();
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) == 0) frame(8'($urandom), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      else begin
        inp_rd = $urandom_range(0, 2) == 0;
        out_wr = $urandom_range(0, 3) == 0;
        ac_in = 8'($urandom);
        ion = $urandom_range(0, 5) == 0;
        iof = $urandom_range(0, 7) == 0;
        int_ack = $urandom_range(0, 9) == 0;
        err_clr = $urandom_range(0, 9) == 0;
        step();
        {inp_rd, out_wr, ion, iof, int_ack, err_clr} = '0;
      end
    end
    wait_tx_idle();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
